// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_pkg;

  localparam int FIFO_DATA_W_DEFAULT = 16;
  localparam int FIFO_DEPTH_DEFAULT  = 16;

  // Read-mode encodings for the FWFT parameter
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2, usable in parameter defaults
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W flop array, sync write, async read
module fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; contents only matter once the pointers say so
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with optional FWFT read, level and threshold flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEFAULT,
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W    = clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_flush,
  input  logic              fifo_wr_en,
  input  logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_full,
  output logic              fifo_almost_full,
  output logic              fifo_wr_err,
  input  logic              fifo_rd_en,
  output logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_valid,
  output logic              fifo_rd_err,
  output logic              fifo_empty,
  output logic              fifo_almost_empty,
  output logic [ADDR_W:0]   fifo_level
);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_err_q;
  logic              rd_err_q;
  logic              req_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Occupancy and flags come only from the registered pointers; the wrap
  // bit makes the modular difference distinguish full from empty
  assign fifo_level        = wr_ptr - rd_ptr;
  assign fifo_empty        = (fifo_level == '0);
  assign fifo_full         = (fifo_level == FULL_LVL);
  assign fifo_almost_full  = (fifo_level >= AF_LVL);
  assign fifo_almost_empty = (fifo_level <= AE_LVL);
  assign fifo_wr_err       = wr_err_q;
  assign fifo_rd_err       = rd_err_q;

  // Requests are ignored outright (no error) during reset or flush. A read
  // frees a slot in the same edge, so a full FIFO may still take a write
  // alongside an accepted read.
  assign req_ok = ~rst & ~fifo_flush;
  assign rd_acc = req_ok & fifo_rd_en & ~fifo_empty;
  assign wr_acc = req_ok & fifo_wr_en & (~fifo_full | rd_acc);

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (fifo_wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Pointer advance and one-cycle error pulses for rejected requests
  always_ff @(posedge clk) begin
    if (rst || fifo_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      wr_err_q <= fifo_wr_en & ~wr_acc;
      rd_err_q <= fifo_rd_en & ~rd_acc;
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly; valid whenever something is stored
      assign fifo_rd_data  = ram_rdata;
      assign fifo_rd_valid = ~fifo_empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      // Registered read: data lands one cycle after the pop and then holds;
      // flush leaves the data register alone
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (fifo_flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= ram_rdata;
        end
      end

      assign fifo_rd_data  = rd_data_q;
      assign fifo_rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised successor to the team's single-clock 16-bit FIFO. Generalises data width and depth, and adds a selectable first-word-fall-through (FWFT) read mode, a fill-level output, programmable almost-full/almost-empty flags and a synchronous flush. It sits between same-clock producer and consumer blocks as the standard buffering primitive. It keeps the existing full/empty/error-pulse semantics so current benches port over directly.

Parameters:
DATA_W, 16, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), derived; not overridden
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
fifo_flush  in  1  synchronous clear of FIFO contents, active-high
fifo_wr_en  in  1  write request
fifo_wr_data  in  DATA_W  write word
fifo_full  out  1  level == DEPTH
fifo_almost_full  out  1  level >= AF_THRESH
fifo_wr_err  out  1  one-cycle pulse: a write was rejected
fifo_rd_en  in  1  read request (pop)
fifo_rd_data  out  DATA_W  read word
fifo_rd_valid  out  1  standard mode: rd_data valid this cycle; FWFT: equals ~fifo_empty
fifo_empty  out  1  level == 0
fifo_almost_empty  out  1  level <= AE_THRESH
fifo_level  out  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: flop array of DEPTH x DATA_W. Write and read pointers are ADDR_W+1 bits wide; the low ADDR_W bits index the array and the MSB is a wrap bit.
- Level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty and fifo_level derive from registered pointers only. They update in the cycle after the accepting edge.
- Write acceptance: wr_acc = fifo_wr_en & (~full | rd_acc). On a write into a full FIFO with a simultaneous accepted read, both are accepted and level stays at DEPTH.
- Read acceptance: rd_acc = fifo_rd_en & ~empty. A read on an empty FIFO is rejected even when a write arrives in the same cycle.
- Rejected write: fifo_wr_err = 1 for exactly the cycle after the edge; pointer and memory unchanged.
- Rejected read: fifo_rd_err = 1 for exactly the cycle after the edge; rd_data holds its value.
- Standard mode (FWFT=0):
  - rd_data is registered from mem[rd_ptr] on rd_acc, so latency is 1 cycle.
  - fifo_rd_valid pulses for 1 cycle after each rd_acc.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally while ~empty; rd_en pops the word.
  - Write at edge N: the word is visible on rd_data and empty=0 from cycle N+1.
  - rd_data while empty is don't-care; the bench must not check it.
- Flush:
  - Clears both pointers, level, rd_valid, wr_err and rd_err at the next edge.
  - Any wr_en/rd_en in the same cycle is ignored and raises no error.
  - Memory contents and rd_data register are not cleared.
- Reset (rst=1 at an edge) clears all state:
  - Pointers and level = 0; rd_data = 0; rd_valid, wr_err, rd_err = 0.
  - Output values: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH==0).
  - Memory is not cleared.
  - Reset mid-operation discards contents; it takes priority over flush and all requests.
- Pointer wrap-around is natural binary rollover; no special case.

Decomposition:
- Shared package `fifo_pkg`: clog2 helper function, default DATA_W/DEPTH constants, FWFT mode encodings (FIFO_STD=0, FIFO_FWFT=1).
- One sub-module, `fifo_ram`: DEPTH x DATA_W flop array with one synchronous write port and one combinational read port.
- Pointer, flag and output-register logic stays in the top level.

Test Plan:
(All scenarios use DATA_W=16, DEPTH=16, AF_THRESH=12, AE_THRESH=2.)
1. Std mode: rst, then write 1..16 -> full=1 and level=16 after the 16th edge, almost_full=1 from level 12, 17th write gives wr_err pulse, data 17 lost; read 16 -> data 1..16 in order, each rd_valid 1 cycle after rd_en, empty=1 at end.
2. Std mode: read on empty with simultaneous write of 0x00AA -> rd_err pulse, level=1 next cycle; next read returns 0x00AA.
3. Full FIFO, simultaneous wr (0xBEEF) and rd -> no wr_err, level stays 16; draining 16 words returns 0xBEEF last.
4. FWFT=1: single write 0x1234 at edge N -> empty=0 and rd_data=0x1234 at cycle N+1 with no rd_en; rd_en pops -> empty=1 next cycle.
5. Write 40 words while reading continuously (pointers wrap twice) -> output sequence 1..40 exact, no errors, level never exceeds 16.
6. Level 9 plus flush asserted together with wr_en -> next cycle level=0, empty=1, almost_empty=1, no wr_err; rst asserted mid-stream -> all outputs at reset values the cycle after.
